spi_master: RTL and testbench
=============================

# spi_master

SPI master that runs one 8-bit full-duplex frame per request: it drives cs, sclk and mosi, and samples miso. It talks to the FPGA's SPI slave port or to external SPI peripherals. It sits behind the same sys_clk domain as the rest of the protocol layer and is driven by a simple start/busy/done handshake. Clock polarity and phase are compile-time parameters and must match the far end.

## Interface
- CPOL, 1'b1, sclk idle level.
- CPHA, 1'b1, 0: sample on the first sclk edge of each bit; 1: sample on the second sclk edge of each bit.
- sys_clk  in  1  system clock; all logic runs on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- data_tx  in  8  byte to transmit, MSB first; latched when start is accepted.
- clk_div_val  in  16  sclk half-period minus one, in sys_clk cycles; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- data_rx  out  8  last received byte; updated in the cycle done asserts, held otherwise.
- cs  out  1  chip select, active low, registered.
- sclk  out  1  serial clock, registered; equals CPOL whenever idle.
- mosi  out  1  serial data out, registered.
- miso  in  1  serial data in.

## Operation
- Half-period H = clk_div_val + 1 cycles (range 1..65536). A 16-bit counter counts 0..clk_div_val; one sclk edge is issued at each wrap.
- States and transitions:
  - IDLE: on start=1 go to SETUP.
  - SETUP: after H cycles go to SHIFT.
  - SHIFT: go to HOLD after the 16th edge.
  - HOLD: after H cycles go to DONE.
  - DONE: always go to IDLE.
- Register states:
  - IDLE: cs=1, sclk=CPOL, mosi=0.
  - SETUP: cs=0; mosi=data_tx[7] (latched copy).
  - SHIFT: issues 16 edges, H cycles apart. An edge counter (5 bits, 1..16) selects the action at each edge.
  - HOLD: cs stays 0, sclk=CPOL.
  - DONE: cs=1, mosi=0, done=1, data_rx loaded from the rx shift register.
- CPHA=0 edge actions:
  - Odd edges (1,3..15) sample miso into rx_shift LSB, shifting left.
  - Even edges (2..14) launch the next mosi bit (bits 6..0).
  - Edge 16 launches nothing.
- CPHA=1 edge actions:
  - Odd edges (1..15) launch bits 7..0; edge 1 re-drives bit 7.
  - Even edges (2..16) sample miso.
- Sampling: miso is sampled in the same sys_clk cycle the sample edge is registered, i.e. the value present just before the sclk transition.
- sclk toggles at every edge. After 16 edges sclk is back at CPOL.
- start while busy (any non-IDLE state, including DONE) is ignored; no queuing.
- data_tx and clk_div_val changes during a frame have no effect.
- Reset (asynchronous, any time, including mid-frame) forces:
  - state IDLE, cs=1, sclk=CPOL, mosi=0, busy=0, done=0, data_rx=8'h00;
  - counters and shift registers cleared.
- The partial frame is discarded and no done pulse is generated.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Cycle 1: SETUP, cs=0, busy=1.
- Edge k (k=1..16) is registered at cycle 1 + k·H.
- Cycle 1 + 17·H: DONE; cs=1, done=1, data_rx valid.
- Cycle 2 + 17·H: IDLE, busy=0; start is accepted in this same cycle.
- Latency from start to done is 1 + 17·H cycles. With clk_div_val=0 this is 18 cycles.
- Minimum cs-high time between frames is 2 cycles: DONE plus the accepting IDLE cycle.
- sclk period is 2·H cycles. cs-low-to-first-edge and last-edge-to-cs-high are each H cycles.

## Test plan
- Mode 3 (CPOL=1, CPHA=1) loopback, miso tied to mosi:
  - Stimulus: data_tx=8'hA5, clk_div_val=0, start pulse at cycle 0.
  - Required: done at cycle 18, data_rx=8'hA5, exactly 16 sclk edges, sclk idles high.
- Mode 0 (CPOL=0, CPHA=0) against a behavioral slave returning 8'h3C:
  - Stimulus: data_tx=8'hC3, clk_div_val=3.
  - Required: edges at cycles 5, 9, … 65; done at cycle 69; slave captures 8'hC3; data_rx=8'h3C.
- Busy rejection:
  - Stimulus: second start pulses at cycle 5 and in the DONE cycle.
  - Required: only one frame occurs; one done pulse; cs stays low continuously until DONE.
- Reset mid-frame:
  - Stimulus: assert sys_rst_n=0 after edge 7.
  - Required: cs=1, sclk=CPOL, mosi=0, busy=0, data_rx=8'h00 immediately; no done pulse.
  - Then a new frame with data_tx=8'h5A in loopback completes with data_rx=8'h5A.
- Back-to-back:
  - Stimulus: start held high, data_tx 8'h01 then 8'h80, clk_div_val=1.
  - Required: cs high for exactly 2 cycles between frames; both bytes correct in loopback; two done pulses 36 cycles apart.

Source files
------------

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_if
// Purpose  : Handshake and serial-bus bundle for spi_master. The master
//            modport is used by the SPI master itself. The slave modport is
//            used by whatever drives the requests and models the far end.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_if;
    logic        start_i;
    logic [7:0]  data_tx_i;
    logic [15:0] clk_div_val_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  data_rx_o;
    logic        cs_o;
    logic        sclk_o;
    logic        mosi_o;
    logic        miso_i;

    modport master (
        input  start_i, data_tx_i, clk_div_val_i, miso_i,
        output busy_o, done_o, data_rx_o, cs_o, sclk_o, mosi_o
    );

    modport slave (
        output start_i, data_tx_i, clk_div_val_i, miso_i,
        input  busy_o, done_o, data_rx_o, cs_o, sclk_o, mosi_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : One 8-bit full-duplex SPI frame per start request. The module
//            drives cs, sclk and mosi, and samples miso. CPOL and CPHA are
//            fixed at elaboration.
//            Each half-period is clk_div_val+1 sys_clk cycles. The frame uses
//            16 sclk edges.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter logic CPOL = 1'b1,
    parameter logic CPHA = 1'b1
) (
    input  wire logic    sys_clk,
    input  wire logic    sys_rst_n,
    spi_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;        // half-period counter, 0..div_q
    logic [15:0] div_q;        // latched clk_div_val
    logic [4:0]  edge_q;       // number of the last sclk edge issued (0 = none yet)
    logic [7:0]  tx_q;         // latched transmit byte
    logic [7:0]  rx_shift_q;   // receive shift register, MSB first
    logic [7:0]  data_rx_q;
    logic        busy_q;
    logic        done_q;
    logic        cs_q;
    logic        sclk_q;
    logic        mosi_q;

    logic        wrap_d;       // half-period elapses at this clock edge
    logic [15:0] cnt_d;
    logic [4:0]  edge_d;       // number of the edge issued at the next wrap
    logic [2:0]  bit_idx_d;    // transmit bit launched on edge_d
    logic        launch_d;
    logic        sample_d;

    // Timing and edge-action decode for the next sclk edge.
    always_comb begin
        wrap_d    = (cnt_q == div_q);
        cnt_d     = wrap_d ? 16'd0 : cnt_q + 16'd1;
        edge_d    = edge_q + 5'd1;
        // CPHA=0 launches bit 7-k on edge 2k.
        // CPHA=1 launches bit 7-k on edge 2k+1.
        // In both cases this is 7 - edge_d[3:1].
        bit_idx_d = 3'd7 - edge_d[3:1];
        if (CPHA) begin
            launch_d = edge_d[0];
            sample_d = ~edge_d[0];
        end else begin
            launch_d = ~edge_d[0] && (edge_d != 5'd16);
            sample_d = edge_d[0];
        end
    end

    // Frame sequencer with all bus outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            div_q      <= 16'd0;
            edge_q     <= 5'd0;
            tx_q       <= 8'h00;
            rx_shift_q <= 8'h00;
            data_rx_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_q    <= ST_SETUP;
                        tx_q       <= bus.data_tx_i;
                        div_q      <= bus.clk_div_val_i;
                        cnt_q      <= 16'd0;
                        edge_q     <= 5'd0;
                        rx_shift_q <= 8'h00;
                        busy_q     <= 1'b1;
                        cs_q       <= 1'b0;
                        mosi_q     <= bus.data_tx_i[7];
                    end
                end

                // SETUP ends with edge 1, registered on its wrap.
                // SHIFT then issues edges 2..16.
                ST_SETUP, ST_SHIFT: begin
                    cnt_q <= cnt_d;
                    if (wrap_d) begin
                        edge_q <= edge_d;
                        sclk_q <= ~sclk_q;
                        if (launch_d) begin
                            mosi_q <= tx_q[bit_idx_d];
                        end
                        if (sample_d) begin
                            rx_shift_q <= {rx_shift_q[6:0], bus.miso_i};
                        end
                        state_q <= (edge_d == 5'd16) ? ST_HOLD : ST_SHIFT;
                    end
                end

                ST_HOLD: begin
                    cnt_q  <= cnt_d;
                    sclk_q <= CPOL;
                    if (wrap_d) begin
                        state_q   <= ST_DONE;
                        cs_q      <= 1'b1;
                        mosi_q    <= 1'b0;
                        done_q    <= 1'b1;
                        data_rx_q <= rx_shift_q;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cs_q    <= 1'b1;
                    sclk_q  <= CPOL;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.data_rx_o = data_rx_q;
    assign bus.cs_o      = cs_q;
    assign bus.sclk_o    = sclk_q;
    assign bus.mosi_o    = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Directed and randomized frames against two spi_master instances.
//            One instance runs mode 0 and talks to a behavioural slave. The
//            other runs mode 3 with miso looped back to mosi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Stimulus shared by both instances; sel picks the active one (1 = mode 3).
    logic        sel     = 1'b0;
    logic        t_start = 1'b0;
    logic [7:0]  t_tx    = 8'h00;
    logic [15:0] t_div   = 16'h0000;

    spi_master_if if0 ();
    spi_master_if if3 ();

    spi_master #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (if0.master)
    );

    spi_master #(.CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (if3.master)
    );

    // Behavioural mode-0 slave: shifts out sl_byte and captures mosi.
    logic [7:0] sl_byte      = 8'h00;
    logic [7:0] sl_sh        = 8'h00;
    logic [7:0] sl_cap       = 8'h00;
    logic       sl_miso      = 1'b0;
    logic       sl_cs_prev   = 1'b1;
    logic       sl_sclk_prev = 1'b0;

    assign if0.start_i       = t_start & ~sel;
    assign if3.start_i       = t_start & sel;
    assign if0.data_tx_i     = t_tx;
    assign if3.data_tx_i     = t_tx;
    assign if0.clk_div_val_i = t_div;
    assign if3.clk_div_val_i = t_div;
    assign if0.miso_i        = sl_miso;
    assign if3.miso_i        = if3.mosi_o;

    logic       m_cs, m_sclk, m_mosi, m_busy, m_done;
    logic [7:0] m_rx;
    assign m_cs   = sel ? if3.cs_o      : if0.cs_o;
    assign m_sclk = sel ? if3.sclk_o    : if0.sclk_o;
    assign m_mosi = sel ? if3.mosi_o    : if0.mosi_o;
    assign m_busy = sel ? if3.busy_o    : if0.busy_o;
    assign m_done = sel ? if3.done_o    : if0.done_o;
    assign m_rx   = sel ? if3.data_rx_o : if0.data_rx_o;

    // Slave model: load on the cs fall, capture on rising sclk, launch on falling sclk.
    always @(negedge clk) begin
        sl_cs_prev   <= if0.cs_o;
        sl_sclk_prev <= if0.sclk_o;
        if (sl_cs_prev === 1'b1 && if0.cs_o === 1'b0) begin
            sl_sh   <= sl_byte;
            sl_miso <= sl_byte[7];
            sl_cap  <= 8'h00;
        end else if (if0.cs_o === 1'b0 && sl_sclk_prev !== if0.sclk_o) begin
            if (if0.sclk_o) begin
                sl_cap <= {sl_cap[6:0], if0.mosi_o};
            end else begin
                sl_sh   <= {sl_sh[6:0], 1'b0};
                sl_miso <= sl_sh[6];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_cs0",   {31'd0, if0.cs_o},   32'd1);
        check("rst_sclk0", {31'd0, if0.sclk_o}, 32'd0);
        check("rst_cs3",   {31'd0, if3.cs_o},   32'd1);
        check("rst_sclk3", {31'd0, if3.sclk_o}, 32'd1);
        check("rst_mosi",  {30'd0, if0.mosi_o, if3.mosi_o}, 32'd0);
        check("rst_busy",  {30'd0, if0.busy_o, if3.busy_o}, 32'd0);
        check("rst_done",  {30'd0, if0.done_o, if3.done_o}, 32'd0);
        check("rst_rx",    {16'd0, if0.data_rx_o, if3.data_rx_o}, 32'd0);
    endtask

    // One frame on the selected instance. Extra start pulses are driven in
    // cycles pa and pb; cycle 0 is the cycle in which start is accepted.
    // The reference model gives the following expectations:
    //   edge k falls at cycle 1+k*H
    //   done falls at cycle 1+17*H
    //   cs is low in cycles 1..17*H
    //   the received byte is tx (loopback) or sb (slave)
    task automatic frame(input logic s, input logic [7:0] tx, input logic [15:0] dv,
                         input logic [7:0] sb, input int pa, input int pb);
        int         h        = int'(dv) + 1;
        int         last     = 17 * h + 4;
        int         edges    = 0;
        int         done_cnt = 0;
        int         done_at  = -1;
        logic       ok_edge  = 1'b1;
        logic       ok_cs    = 1'b1;
        logic       ok_busy  = 1'b1;
        logic       prev     = s;
        logic [7:0] rx_done  = 8'hxx;
        logic [7:0] exp_rx   = s ? tx : sb;
        @(negedge clk);
        sel     = s;
        sl_byte = sb;
        t_start = 1'b1;
        t_tx    = tx;
        t_div   = dv;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            t_start = (c == pa) || (c == pb);
            if (c == 1) begin
                t_tx  = 8'($urandom);
                t_div = 16'($urandom_range(0, 7));
            end
            if (m_sclk !== prev) begin
                edges++;
                if (c != 1 + edges * h) ok_edge = 1'b0;
                prev = m_sclk;
            end
            if (c <= 17 * h && m_cs !== 1'b0) ok_cs = 1'b0;
            if (c > 17 * h && m_cs !== 1'b1) ok_cs = 1'b0;
            if (c <= 1 + 17 * h && m_busy !== 1'b1) ok_busy = 1'b0;
            if (c >= 2 + 17 * h && m_busy !== 1'b0) ok_busy = 1'b0;
            if (m_done === 1'b1) begin
                done_cnt++;
                done_at = c;
                rx_done = m_rx;
            end
        end
        check("edge_count",  edges, 16);
        check("edge_times",  {31'd0, ok_edge}, 32'd1);
        check("done_count",  done_cnt, 1);
        check("done_cycle",  done_at, 1 + 17 * h);
        check("data_rx",     {24'd0, rx_done}, {24'd0, exp_rx});
        check("rx_held",     {24'd0, m_rx}, {24'd0, exp_rx});
        check("cs_window",   {31'd0, ok_cs}, 32'd1);
        check("busy_window", {31'd0, ok_busy}, 32'd1);
        check("sclk_idle",   {31'd0, m_sclk}, {31'd0, s});
        check("mosi_idle",   {31'd0, m_mosi}, 32'd0);
        if (!s) check("slave_cap", {24'd0, sl_cap}, {24'd0, tx});
    endtask

    initial begin
        int         dcnt;
        int         d1;
        int         d2;
        int         cs_hi;
        int         late_done;
        logic       busy_bad;
        logic [7:0] rx1;
        logic [7:0] rx2;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 3 loopback, A5, H=1.
        frame(1'b1, 8'hA5, 16'd0, 8'h00, -1, -1);
        // Mode 0 against slave returning 3C, H=4.
        frame(1'b0, 8'hC3, 16'd3, 8'h3C, -1, -1);
        // Busy rejection: extra starts at cycle 5 and in DONE (H=2, DONE = 35).
        frame(1'b0, 8'h96, 16'd1, 8'h69, 5, 35);

        // Randomized frames on both modes.
        for (int i = 0; i < 4; i++) begin
            frame(1'b0, 8'($urandom), 16'($urandom_range(0, 4)), 8'($urandom), -1, -1);
            frame(1'b1, 8'($urandom), 16'($urandom_range(0, 4)), 8'h00, -1, -1);
        end
        frame(1'b1, 8'hA5, 16'd0, 8'h00, -1, -1);

        // Reset mid-frame after edge 7 (H=3, edge 7 registered at cycle 22).
        @(negedge clk);
        sel     = 1'b1;
        t_start = 1'b1;
        t_tx    = 8'h96;
        t_div   = 16'd2;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            t_start = 1'b0;
        end
        check("busy_before_rst", {31'd0, if3.busy_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        rst_n     = 1'b1;
        late_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (if3.done_o !== 1'b0 || if0.done_o !== 1'b0 || if3.busy_o !== 1'b0) late_done++;
        end
        check("no_done_after_rst", late_done, 0);
        frame(1'b1, 8'h5A, 16'($urandom_range(0, 3)), 8'h00, -1, -1);

        // Back-to-back with start held high, H=2: frame length 36 cycles.
        @(negedge clk);
        sel       = 1'b1;
        t_start   = 1'b1;
        t_tx      = 8'h01;
        t_div     = 16'd1;
        dcnt      = 0;
        d1        = -1;
        d2        = -1;
        cs_hi     = 0;
        busy_bad  = 1'b0;
        rx1       = 8'hxx;
        rx2       = 8'hxx;
        for (int c = 1; c <= 76; c++) begin
            @(negedge clk);
            if (c == 1)  t_tx    = 8'h80;
            if (c == 72) t_start = 1'b0;
            if (if3.done_o === 1'b1) begin
                dcnt++;
                if (dcnt == 1) begin
                    d1  = c;
                    rx1 = if3.data_rx_o;
                end else begin
                    d2  = c;
                    rx2 = if3.data_rx_o;
                end
            end
            if (c >= 2 && c <= 70 && if3.cs_o !== 1'b0) cs_hi++;
            if (c >= 74 && if3.busy_o !== 1'b0) busy_bad = 1'b1;
        end
        check("b2b_done_count", dcnt, 2);
        check("b2b_first_done", d1, 35);
        check("b2b_spacing",    d2 - d1, 36);
        check("b2b_rx1",        {24'd0, rx1}, 32'h01);
        check("b2b_rx2",        {24'd0, rx2}, 32'h80);
        check("b2b_cs_high",    cs_hi, 2);
        check("b2b_idle_after", {31'd0, busy_bad}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
